// File: rtl/bp_bht_update_queue_if.sv
// Prediction/resolution/write-back bundle between the pipeline, the BHT and
// the BHT update queue. The queue takes the slave side; the driver of
// predictions and resolutions (pipeline or bench) takes the master side.
interface bp_bht_update_queue_if #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             pred_v_i;
    logic [PC_W-1:0]  pred_pc_i;
    logic             pred_dir_i;
    logic             pred_ready_o;
    logic             res_v_i;
    logic             res_taken_i;
    logic             flush_i;
    logic             bht_w_o;
    logic [PC_W-1:0]  bht_w_pc_o;
    logic             correct_o;
    logic [PTR_W:0]   count_o;
    logic             empty_o;
    logic             ovf_o;
    logic             unf_o;

    modport slave (
        input  pred_v_i, pred_pc_i, pred_dir_i, res_v_i, res_taken_i, flush_i,
        output pred_ready_o, bht_w_o, bht_w_pc_o, correct_o, count_o, empty_o,
               ovf_o, unf_o
    );

    modport master (
        output pred_v_i, pred_pc_i, pred_dir_i, res_v_i, res_taken_i, flush_i,
        input  pred_ready_o, bht_w_o, bht_w_pc_o, correct_o, count_o, empty_o,
               ovf_o, unf_o
    );
endinterface

// File: rtl/bp_bht_update_queue.sv
// In-order holding queue for BHT predictions awaiting resolution. Each
// resolution pops the oldest entry and emits one registered BHT write carrying
// the branch PC and whether the stored prediction was correct. A flush squashes
// every entry still in flight after any same-cycle resolve has been served.
module bp_bht_update_queue #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bp_bht_update_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Registered state
    logic [PC_W-1:0]  mem_pc_q  [DEPTH];
    logic             mem_dir_q [DEPTH];
    logic [PTR_W-1:0] wp_q, rp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bht_w_q;
    logic [PC_W-1:0]  bht_w_pc_q;
    logic             correct_q;
    logic             ovf_q, unf_q;

    // Next-state values
    logic [PC_W-1:0]  mem_pc_d  [DEPTH];
    logic             mem_dir_d [DEPTH];
    logic [PTR_W-1:0] wp_d, rp_d;
    logic [CNT_W-1:0] cnt_d;
    logic             bht_w_d;
    logic [PC_W-1:0]  bht_w_pc_d;
    logic             correct_d;
    logic             ovf_d, unf_d;

    // Decoded handshake conditions
    logic full_s, empty_s, enq_s, deq_s;

    // Occupancy decode and accepted enqueue/resolve; all gated on pre-edge state
    always_comb begin
        full_s  = (cnt_q == CNT_W'(DEPTH));
        empty_s = (cnt_q == {CNT_W{1'b0}});
        enq_s   = q.pred_v_i && !full_s && !q.flush_i;
        deq_s   = q.res_v_i && !empty_s;
    end

    // Next-state for storage, pointers, occupancy, write port and sticky flags
    always_comb begin
        mem_pc_d  = mem_pc_q;
        mem_dir_d = mem_dir_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        cnt_d     = cnt_q;

        if (enq_s) begin
            mem_pc_d[wp_q]  = q.pred_pc_i;
            mem_dir_d[wp_q] = q.pred_dir_i;
            wp_d            = wp_q + PTR_W'(1);
        end else begin
            wp_d = wp_q;
        end

        if (q.flush_i) begin
            // Any same-cycle enqueue was already suppressed, so wp_q is final
            rp_d  = wp_q;
            cnt_d = {CNT_W{1'b0}};
        end else begin
            if (deq_s) begin
                rp_d = rp_q + PTR_W'(1);
            end else begin
                rp_d = rp_q;
            end
            case ({enq_s, deq_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        bht_w_d = deq_s;
        if (deq_s) begin
            bht_w_pc_d = mem_pc_q[rp_q];
            correct_d  = (mem_dir_q[rp_q] == q.res_taken_i);
        end else begin
            bht_w_pc_d = bht_w_pc_q;
            correct_d  = correct_q;
        end

        // A prediction that arrives during a flush is squashed, not overflowed
        ovf_d = ovf_q | (q.pred_v_i && full_s && !q.flush_i);
        unf_d = unf_q | (q.res_v_i && empty_s);
    end

    // State register; reset drops all entries and kills any pending write
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]  <= {PC_W{1'b0}};
                mem_dir_q[i] <= 1'b0;
            end
            wp_q       <= {PTR_W{1'b0}};
            rp_q       <= {PTR_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            bht_w_q    <= 1'b0;
            bht_w_pc_q <= {PC_W{1'b0}};
            correct_q  <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            mem_pc_q   <= mem_pc_d;
            mem_dir_q  <= mem_dir_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            bht_w_q    <= bht_w_d;
            bht_w_pc_q <= bht_w_pc_d;
            correct_q  <= correct_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Outputs come straight from registered state only
    always_comb begin
        q.pred_ready_o = !full_s;
        q.empty_o      = empty_s;
        q.count_o      = cnt_q;
        q.bht_w_o      = bht_w_q;
        q.bht_w_pc_o   = bht_w_pc_q;
        q.correct_o    = correct_q;
        q.ovf_o        = ovf_q;
        q.unf_o        = unf_q;
    end
endmodule

// File: doc/bp_bht_update_queue.md
# bp_bht_update_queue

In-order holding queue between the tournament BHT's prediction port and its update port. Each prediction (PC plus predicted direction) is captured when issued and held until the branch resolves. On resolution the block emits one registered write to the BHT: write enable, write PC and the correct flag the BHT uses to update its pattern and counter tables. It also squashes in-flight predictions on a pipeline flush.

## Interface
- PC_W, 32, branch PC width; must match the BHT's PC_W.
- DEPTH, 4, number of queue entries; power of two, at least 2.
- PTR_W (localparam), $clog2(DEPTH), read/write pointer width.

- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- pred_v_i  input  1  prediction issued this cycle.
- pred_pc_i  input  PC_W  PC the prediction was made for.
- pred_dir_i  input  1  predicted direction; connected to the BHT's predict_o.
- pred_ready_o  output  1  queue can accept an entry; equals !full.
- res_v_i  input  1  oldest outstanding branch resolved this cycle.
- res_taken_i  input  1  actual branch direction.
- flush_i  input  1  squash all entries that have not resolved.
- bht_w_o  output  1  BHT write enable; one-cycle pulse.
- bht_w_pc_o  output  PC_W  BHT write address.
- correct_o  output  1  1 when the stored prediction matched res_taken_i.
- count_o  output  PTR_W+1  number of occupied entries.
- empty_o  output  1  count_o == 0.
- ovf_o  output  1  sticky flag: an enqueue was attempted while full.
- unf_o  output  1  sticky flag: a resolution arrived while empty.

## Operation
- Storage: circular buffer of DEPTH entries {pc, dir}.
  - Write pointer wp and read pointer rp, each PTR_W bits, wrap modulo DEPTH.
  - Occupancy cnt is PTR_W+1 bits.
- Enqueue: pred_v_i && !full writes {pred_pc_i, pred_dir_i} at wp, then wp+1.
  - pred_v_i while full: entry dropped, ovf_o set, no pointer or count change.
- Resolve: res_v_i && !empty reads the head at rp, then rp+1.
  - Registers bht_w_o=1, bht_w_pc_o=head.pc, correct_o=(head.dir == res_taken_i).
  - res_v_i while empty: ignored, unf_o set, bht_w_o stays 0.
- Simultaneous enqueue and resolve:
  - Both take effect and cnt is unchanged.
  - When full, the resolve proceeds but the enqueue is still refused, because pred_ready_o is evaluated on the pre-edge count.
  - When empty, the enqueued entry is not resolvable in the same cycle; unf_o is set.
- Flush:
  - A resolve in the same cycle is processed first: its write is still emitted.
  - All remaining entries are then discarded: rp<=wp after any enqueue is cancelled, cnt<=0.
  - pred_v_i in a flush cycle is discarded and does not set ovf_o.
- ovf_o and unf_o clear only on reset.
- Reset values:
  - Outputs: bht_w_o=0, bht_w_pc_o=0, correct_o=0, count_o=0, empty_o=1, pred_ready_o=1, ovf_o=0, unf_o=0.
  - Internal: wp=0, rp=0, entry storage=0.
- Reset asserted mid-operation: all in-flight entries are lost and any pending write pulse is cancelled immediately (asynchronous).

## Timing
- Enqueue latency: an entry is visible in count_o in the cycle after the accepting edge.
- Resolve-to-write latency: a resolve sampled at edge N drives bht_w_o high from edge N to edge N+1. The BHT samples bht_w_o, bht_w_pc_o and correct_o at edge N+1.
- Write pulse width: exactly one cycle per resolve. Back-to-back resolves produce bht_w_o high on consecutive cycles with new PC/correct values each cycle.
- bht_w_pc_o and correct_o hold their last values while bht_w_o=0.
- Combinational outputs: pred_ready_o, empty_o and count_o are decoded from registered state only; there is no combinational path from any input.
- Throughput: one enqueue and one resolve per cycle, sustained.
- Minimum enqueue-to-resolve spacing: one edge.

## Test plan
- Reset, then enqueue PC 0x10 dir=1 and PC 0x14 dir=0, then resolve taken=1 and taken=1:
  - bht_w_o pulses on two consecutive cycles.
  - First pulse: bht_w_pc_o=0x10, correct_o=1.
  - Second pulse: bht_w_pc_o=0x14, correct_o=0.
- Fill with DEPTH=4 entries, then assert pred_v_i PC 0x40:
  - pred_ready_o=0, count_o=4, ovf_o=1.
  - Later resolves emit only the first four PCs.
- Full queue, simultaneous pred_v_i PC 0x50 and res_v_i:
  - Head is written.
  - 0x50 is dropped, ovf_o=1, count_o=3.
- Two entries queued, then one cycle with res_v_i=1 taken=0 plus flush_i=1 plus pred_v_i:
  - Exactly one write for the head PC.
  - count_o=0, empty_o=1, ovf_o=0.
- res_v_i with the queue empty: no bht_w_o pulse, unf_o=1 stays set.
- Wrap-around: 20 random enqueue/resolve pairs against a reference model; PCs and correct flags match in order, with pointers wrapping 5 times.
- Assert reset_i asynchronously while bht_w_o=1: bht_w_o drops without waiting for a clock edge and count_o=0.
